// File: rtl/serial_shift_in_pkg.sv
// rtl/serial_shift_in_pkg.sv - shared types and sizing helpers for serial_shift_in
package serial_shift_in_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_shift_in.sv
// rtl/serial_shift_in.sv - framed serial-to-parallel word assembler with one output buffer
import serial_shift_in_pkg::*;

module serial_shift_in #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sdi,
  input  logic             sdi_valid,
  input  logic             frame,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             load,
  output logic             overrun,
  output logic             frame_err,
  input  logic             err_clr
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic             accept;
  logic             complete;
  logic             ferr_evt;

  assign accept = sdi_valid & frame;
  assign load   = word_valid & word_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    complete  = 1'b0;
    ferr_evt  = 1'b0;
    if (accept) begin
      sr_nxt = MSB_FIRST ? {sr[WIDTH-2:0], sdi} : {sdi, sr[WIDTH-1:1]};
    end
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt   = CW'(1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (accept) begin
          if (cnt == CW'(WIDTH - 1)) begin
            complete  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end else if (!frame) begin
          // partial word abandoned; sr is simply overwritten by the next word
          ferr_evt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
      // a completing word may replace the buffered one only if it is consumed this edge
      if (complete && (!word_valid || word_ready)) begin
        word_out   <= sr_nxt;
        word_valid <= 1'b1;
      end else if (load) begin
        word_valid <= 1'b0;
      end
      if (complete && word_valid && !word_ready) overrun <= 1'b1;
      else if (err_clr)                          overrun <= 1'b0;
      if (ferr_evt)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_shift_in.sv
// tb/tb_serial_shift_in.sv - self-checking bench for serial_shift_in, both bit orders
module tb_serial_shift_in;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sdi = 1'b0, sdi_valid = 1'b0, frame = 1'b0, word_ready = 1'b0, err_clr = 1'b0;
  logic [7:0] wo_m, wo_l;
  logic       wv_m, wv_l, ld_m, ld_l, ov_m, ov_l, fe_m, fe_l;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_shift_in #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .sdi(sdi), .sdi_valid(sdi_valid), .frame(frame),
    .word_out(wo_m), .word_valid(wv_m), .word_ready(word_ready), .load(ld_m),
    .overrun(ov_m), .frame_err(fe_m), .err_clr(err_clr)
  );

  serial_shift_in #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .sdi(sdi), .sdi_valid(sdi_valid), .frame(frame),
    .word_out(wo_l), .word_valid(wv_l), .word_ready(word_ready), .load(ld_l),
    .overrun(ov_l), .frame_err(fe_l), .err_clr(err_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: collect the bits of the current word in order, then place them by index.
  int         m_cnt = 0;
  bit         m_bits [8];
  logic [7:0] m_word_m = 8'h00, m_word_l = 8'h00, n_m, n_l;
  bit         m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
  bit         m_done, m_fe_set, m_ov_set;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_valid = 0; m_word_m = 8'h00; m_word_l = 8'h00; m_ovr = 0; m_ferr = 0;
    end else begin
      m_done = 0; m_fe_set = 0; m_ov_set = 0; n_m = 8'h00; n_l = 8'h00;
      if (sdi_valid && frame) begin
        m_bits[m_cnt] = sdi;
        m_cnt++;
        if (m_cnt == 8) begin
          for (int i = 0; i < 8; i++) begin
            n_m[7-i] = m_bits[i];
            n_l[i]   = m_bits[i];
          end
          m_done = 1;
          m_cnt  = 0;
        end
      end else if (!frame && m_cnt > 0) begin
        m_fe_set = 1;
        m_cnt    = 0;
      end
      if (m_done) begin
        if (!m_valid || word_ready) begin
          m_word_m = n_m; m_word_l = n_l; m_valid = 1;
        end else begin
          m_ov_set = 1;
        end
      end else if (m_valid && word_ready) begin
        m_valid = 0;
      end
      m_ovr  = m_ov_set | (m_ovr & ~err_clr);
      m_ferr = m_fe_set | (m_ferr & ~err_clr);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("msb.word_valid", wv_m, m_valid);
      chk("lsb.word_valid", wv_l, m_valid);
      chk("msb.word_out",   wo_m, m_word_m);
      chk("lsb.word_out",   wo_l, m_word_l);
      chk("msb.load",       ld_m, m_valid & word_ready);
      chk("lsb.load",       ld_l, m_valid & word_ready);
      chk("msb.overrun",    ov_m, m_ovr);
      chk("lsb.overrun",    ov_l, m_ovr);
      chk("msb.frame_err",  fe_m, m_ferr);
      chk("lsb.frame_err",  fe_l, m_ferr);
    end
  end

  task automatic cyc(input logic v, input logic d, input logic f, input logic r, input logic c);
    sdi_valid = v; sdi = d; frame = f; word_ready = r; err_clr = c;
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] w, input logic r_last, input logic r_other);
    for (int i = 7; i >= 0; i--) cyc(1'b1, w[i], 1'b1, (i == 0) ? r_last : r_other, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".word_out"},   {wo_m, wo_l}, 16'h0000);
    chk({tag, ".word_valid"}, {wv_m, wv_l}, 2'b00);
    chk({tag, ".load"},       {ld_m, ld_l}, 2'b00);
    chk({tag, ".flags"},      {ov_m, ov_l, fe_m, fe_l}, 4'b0000);
  endtask

  initial begin
    @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);

    // bits 1,0,1,0,0,1,1,0 with ready held high
    send_byte(8'hA6, 1'b1, 1'b1);
    chk("t1.msb_word", wo_m, 8'hA6);
    chk("t2.lsb_word", wo_l, 8'h65);
    chk("t1.valid",    wv_m, 1'b1);
    chk("t1.load",     ld_m, 1'b1);
    cyc(0, 0, 0, 1, 0);
    chk("t1.valid_pulse", wv_m, 1'b0);

    // back-to-back words into a stalled consumer
    send_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    chk("t3.word_kept", wo_m, 8'h3C);
    chk("t3.overrun",   ov_m, 1'b1);
    cyc(0, 0, 0, 0, 1);
    chk("t3.clr", ov_m, 1'b0);
    cyc(0, 0, 0, 1, 0);
    chk("t3.drain", wv_m, 1'b0);

    // consumer accepts exactly on the second completion
    send_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b0);
    chk("t4.word_new", {wo_m, wo_l}, 16'hC3C3);
    chk("t4.valid",    wv_m, 1'b1);
    chk("t4.overrun",  ov_m, 1'b0);
    cyc(0, 0, 0, 1, 0);

    // frame drops after 5 bits
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t5.frame_err", fe_m, 1'b1);
    chk("t5.no_valid",  wv_m, 1'b0);
    send_byte(8'h81, 1'b1, 1'b1);
    chk("t5.word", {wo_m, wo_l}, 16'h8181);
    cyc(0, 0, 0, 1, 1);
    chk("t5.clr", fe_m, 1'b0);

    // async reset mid-word
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 1, 0);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t6.mid_word");
    cyc(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    // async reset while a word is held
    send_byte(8'hE7, 1'b0, 1'b0);
    chk("t6.held", wv_m, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t6.mid_hold");
    cyc(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    send_byte(8'h5A, 1'b1, 1'b1);
    chk("t6.word", {wo_m, wo_l}, 16'h5A5A);
    chk("t6.valid", wv_m, 1'b1);

    // randomized traffic, checked every cycle against the reference
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom % 10) < 7, $urandom % 2, ($urandom % 40) != 0,
          $urandom % 2, ($urandom % 20) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
